mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have port Clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port Reset, input, 1, asynchronous, active-high.
REQ-003 The block SHALL have port Start, input, 1, request a new operation; sampled only in IDLE.
REQ-004 The block SHALL have port Op, input, 2, operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 The block SHALL have port A, input, 32, operand 1 (multiplicand or dividend), driven from GPR RData1.
REQ-006 The block SHALL have port B, input, 32, operand 2 (multiplier or divisor), driven from GPR RData2.
REQ-007 The block SHALL have port HiWrite, input, 1, write WData to Hi (MTHI).
REQ-008 The block SHALL have port LoWrite, input, 1, write WData to Lo (MTLO).
REQ-009 The block SHALL have port WData, input, 32, data for HiWrite and LoWrite.
REQ-010 The block SHALL have port Busy, output, 1, operation in progress.
REQ-011 The block SHALL have port Done, output, 1, one-cycle pulse when Hi and Lo hold a new result.
REQ-012 The block SHALL have ports Hi and Lo, output, 32 each, registered result (Hi: product[63:32] or remainder; Lo: product[31:0] or quotient).

Function
REQ-013 The block SHALL implement the states IDLE, CALC and FIX; Busy SHALL be 1 exactly when the state is CALC or FIX.
REQ-014 In IDLE with Start=1 at edge E0, the block SHALL latch Op, A and B and move to CALC; later changes on A, B or Op SHALL NOT affect the result.
REQ-015 For signed ops, the block SHALL latch operand magnitudes and the result signs at E0; unsigned ops SHALL use the operands as given.
REQ-016 CALC SHALL last exactly 32 cycles (edges E1..E32), resolving one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 At E33 (FIX), the block SHALL apply the sign correction, write Hi and Lo, pulse Done high for the cycle after E33, and return to IDLE.
REQ-018 Busy SHALL be high for 33 cycles (E0 to E33); the next Start SHALL be accepted at E34 at the earliest.
REQ-019 Signed multiply SHALL produce the two's-complement 64-bit product; the product SHALL be negative iff exactly one operand is negative.
REQ-020 Signed divide SHALL truncate toward zero; the quotient sign SHALL be sign(A) xor sign(B), and the remainder SHALL take the sign of A.
REQ-021 Divide by zero (B=0, DIV or DIVU) SHALL give Lo=32'hFFFFFFFF and Hi=A, with no exception and the normal 33-cycle latency.
REQ-022 DIV with A=32'h80000000 and B=32'hFFFFFFFF SHALL give Lo=32'h80000000 and Hi=0.
REQ-023 Start, HiWrite and LoWrite SHALL be ignored while Busy=1.
REQ-024 In IDLE, HiWrite and LoWrite SHALL update Hi or Lo at the edge; both may be asserted in the same cycle.
REQ-025 In IDLE, Start SHALL take priority over a simultaneous HiWrite or LoWrite, and that write SHALL be dropped.
REQ-026 Hi and Lo SHALL hold their value between writes; Hi and Lo SHALL NOT change during CALC.

Reset
REQ-027 Reset=1 SHALL immediately force state IDLE, Busy=0, Done=0, Hi=0, Lo=0 and clear all internal operand and iteration registers, regardless of the clock.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no partial result visible; after Reset falls, the first Start SHALL behave as from power-up.

Verification
REQ-029 MULTU with A=7, B=6 -> Busy high 33 cycles, then Done pulse, Hi=0, Lo=42.
REQ-030 MULT with A=-3, B=5 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFF1; MULTU with A=B=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=1.
REQ-031 DIV with A=-7, B=2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF; DIVU with A=7, B=2 -> Lo=3, Hi=1.
REQ-032 DIVU with A=100, B=0 -> Lo=32'hFFFFFFFF, Hi=100; DIV with A=32'h80000000, B=-1 -> Lo=32'h80000000, Hi=0.
REQ-033 Start, then a second Start with new operands and HiWrite=1, WData=5 at cycle 10 -> both ignored; the first result appears unchanged at E33.
REQ-034 Reset pulse at cycle 15 of a MULT -> Busy=0, Hi=0, Lo=0 at once, no Done; a new MULTU 3*4 after reset -> Lo=12.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with Hi/Lo result registers.
// It resolves one bit per cycle, so each operation takes 33 cycles.
module mul_div_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [1:0]  dbg_state
);

  // Handshake: Start is accepted only while Busy=0. Busy then stays high for
  // 33 cycles. Done pulses for the one cycle in which the new Hi/Lo first show.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        is_div_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt_q;
  logic        neg_lo_q, neg_hi_q;

  logic        sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_rem, div_diff;
  logic        div_ok;
  logic [63:0] step_next, prod_neg;

  assign Busy      = (state != IDLE);
  assign dbg_state = state;

  assign sa    = Op[0] & A[31];
  assign sb    = Op[0] & B[31];
  assign mag_a = sa ? -A : A;
  assign mag_b = sb ? -B : B;

  // Multiply: add the multiplicand to the upper half when the low bit is set,
  // then shift right. Divide: restoring shift-subtract of remainder:quotient.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_rem  = acc_q[63:31];
  assign div_diff = div_rem - {1'b0, opnd_q};
  assign div_ok   = ~div_diff[32];
  assign prod_neg = -acc_q;

  always_comb begin
    step_next = {mul_sum, acc_q[31:1]};
    if (is_div_q)
      step_next = {(div_ok ? div_diff[31:0] : div_rem[31:0]), acc_q[30:0], div_ok};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = CALC;
      CALC:    if (cnt_q == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            is_div_q <= Op[1];
            cnt_q    <= '0;
            if (Op[1]) begin
              opnd_q   <= mag_b;
              acc_q    <= {32'd0, mag_a};
              // A zero divisor keeps the all-ones quotient unsigned.
              neg_lo_q <= (sa ^ sb) & (B != 32'd0);
              neg_hi_q <= sa;
            end else begin
              opnd_q   <= mag_a;
              acc_q    <= {32'd0, mag_b};
              neg_lo_q <= sa ^ sb;
              neg_hi_q <= sa ^ sb;
            end
          end else begin
            if (HiWrite) Hi <= WData;
            if (LoWrite) Lo <= WData;
          end
        end
        CALC: begin
          acc_q <= step_next;
          cnt_q <= cnt_q + 5'd1;
        end
        FIX: begin
          Done <= 1'b1;
          if (is_div_q) begin
            Lo <= neg_lo_q ? prod_neg[31:0] : acc_q[31:0];
            Hi <= neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
          end else begin
            {Hi, Lo} <= neg_lo_q ? prod_neg : acc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
